// File: rtl/vga_pkg.sv
// VGA 640x480@60 scan-out: shared timing constants,
// pixel/pipeline bundles and the RGB333 -> RGB888 expansion.
package vga_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE  = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int FB_SHIFT  = 2;
    localparam int FB_WIDTH  = 160;
    localparam int FB_ADDR_W = 15;

    localparam int H_CNT_W   = 10;
    localparam int V_CNT_W   = 10;

    localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_VIS      = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] HS_FIRST   = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W-1:0] HS_LAST    = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_VIS      = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] VS_FIRST   = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] VS_LAST    = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Framebuffer word layout {r[8:6], g[5:3], b[2:0]}
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb333_t;

    // Flags captured alongside the address fetch
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } s1_t;

    // Connector-side registered outputs
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank_n;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vga_out_t;

    // Replicate the 3-bit level so full scale maps to 8'hFF
    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel tick, raster counters and frame pulse for the scan-out;
// visible/sync flags are decoded combinationally from the counters.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    output logic               tick,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               frame_start,
    output logic               visible,
    output logic               hs,
    output logic               vs
);

    logic               tick_q, tick_d;
    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic               frame_start_q, frame_start_d;

    // Next raster position; advances only on the pixel tick phase
    always_comb begin
        tick_d        = ~tick_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = 1'b0;
        if (tick_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d       = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + V_CNT_W'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + H_CNT_W'(1);
            end
        end
    end

    // Timing state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_q        <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign tick        = tick_q;
    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign frame_start = frame_start_q;
    assign visible     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign hs          = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    assign vs          = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: address fetch stage, then a colour/sync stage
// so DAC data and syncs leave together, two pixel ticks behind the raster.
module vga_scanout
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [8:0]           fb_q,
    output logic                 vga_clk,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_blank_n,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b,
    output logic                 frame_start
);

    logic               tick;
    logic               visible;
    logic               hs;
    logic               vs;
    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;

    vga_timing_gen u_timing (
        .clk         (clk),
        .resetn      (resetn),
        .tick        (tick),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .frame_start (frame_start),
        .visible     (visible),
        .hs          (hs),
        .vs          (vs)
    );

    localparam s1_t      S1_RST  = '{active: 1'b0, hs: 1'b1, vs: 1'b1};
    localparam vga_out_t OUT_RST = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0,
                                     r: 8'h00, g: 8'h00, b: 8'h00};

    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [FB_ADDR_W-1:0] row_base;
    logic [FB_ADDR_W-1:0] col_off;
    s1_t                  s1_q, s1_d;
    vga_out_t             out_q, out_d;
    rgb333_t              pix;

    // Fetch address for the current pixel; colour stage uses last tick's flags
    always_comb begin
        pix       = rgb333_t'(fb_q);
        row_base  = FB_ADDR_W'(v_cnt >> FB_SHIFT) * FB_ADDR_W'(FB_WIDTH);
        col_off   = FB_ADDR_W'(h_cnt >> FB_SHIFT);
        fb_addr_d = fb_addr_q;
        s1_d      = s1_q;
        out_d     = out_q;
        if (tick) begin
            if (visible) begin
                fb_addr_d = row_base + col_off;
            end
            s1_d          = '{active: visible, hs: hs, vs: vs};
            out_d.hs      = s1_q.hs;
            out_d.vs      = s1_q.vs;
            out_d.blank_n = s1_q.active;
            out_d.r       = s1_q.active ? expand3(pix.r) : 8'h00;
            out_d.g       = s1_q.active ? expand3(pix.g) : 8'h00;
            out_d.b       = s1_q.active ? expand3(pix.b) : 8'h00;
        end
    end

    // Pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fb_addr_q <= '0;
            s1_q      <= S1_RST;
            out_q     <= OUT_RST;
        end else begin
            fb_addr_q <= fb_addr_d;
            s1_q      <= s1_d;
            out_q     <= out_d;
        end
    end

    assign fb_addr     = fb_addr_q;
    assign vga_clk     = tick;
    assign vga_hs      = out_q.hs;
    assign vga_vs      = out_q.vs;
    assign vga_blank_n = out_q.blank_n;
    assign vga_r       = out_q.r;
    assign vga_g       = out_q.g;
    assign vga_b       = out_q.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: directed steps, framebuffer model and
// a pixel scoreboard keyed on raster position.
module tb_vga_scanout;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [14:0] fb_addr;
    logic [8:0]  fb_q = '0;
    logic        vga_clk;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        frame_start;

    bit ovr = 1'b0;
    int c = 0;
    int ncmp = 0;
    int nfail = 0;
    int fs_cnt = 0;
    int fs_first = -1;

    typedef struct {
        int          pos;
        bit          vis;
        logic [14:0] addr;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        string       tag;
    } exp_t;

    exp_t sb[$];

    vga_scanout dut (
        .clk         (clk),
        .resetn      (resetn),
        .fb_addr     (fb_addr),
        .fb_q        (fb_q),
        .vga_clk     (vga_clk),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    function automatic logic [8:0] pat(input logic [14:0] a);
        return a[8:0] ^ 9'h15a;
    endfunction

    // 3-bit level scaled to 8 bits: v*255/7 rounded as v*73/2
    function automatic logic [7:0] x8(input logic [2:0] v);
        logic [9:0] t;
        t = 10'(v) * 10'd73;
        return t[8:1];
    endfunction

    // Synchronous-read framebuffer model
    always @(posedge clk) fb_q <= ovr ? 9'h1c5 : pat(fb_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int h, input int v, input string tag);
        exp_t        e;
        int          a;
        logic [8:0]  d;
        e.pos  = v * 800 + h;
        e.vis  = (h < 640) && (v < 480);
        a      = (v / 4) * 160 + h / 4;
        e.addr = a[14:0];
        d      = ovr ? 9'h1c5 : pat(e.addr);
        e.r    = e.vis ? x8(d[8:6]) : 8'h00;
        e.g    = e.vis ? x8(d[5:3]) : 8'h00;
        e.b    = e.vis ? x8(d[2:0]) : 8'h00;
        e.hs   = !(h >= 656 && h < 752);
        e.vs   = !(v >= 490 && v < 492);
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic score();
        int t;
        if (resetn && (c % 2 == 0)) begin
            t = c / 2;
            foreach (sb[i]) begin
                if (sb[i].vis && sb[i].pos == t - 1)
                    chk({sb[i].tag, ".addr"}, 32'(fb_addr), 32'(sb[i].addr));
            end
            while (sb.size() > 0 && sb[0].pos <= t - 2) begin
                ncmp++;
                assert (sb[0].pos == t - 2) else begin
                    nfail++;
                    $error("FAIL %s.late: at %0d, expected %0d",
                           sb[0].tag, t - 2, sb[0].pos);
                end
                if (sb[0].pos == t - 2) begin
                    chk({sb[0].tag, ".r"}, 32'(vga_r), 32'(sb[0].r));
                    chk({sb[0].tag, ".g"}, 32'(vga_g), 32'(sb[0].g));
                    chk({sb[0].tag, ".b"}, 32'(vga_b), 32'(sb[0].b));
                    chk({sb[0].tag, ".blank_n"}, 32'(vga_blank_n), 32'(sb[0].vis));
                    chk({sb[0].tag, ".hs"}, 32'(vga_hs), 32'(sb[0].hs));
                    chk({sb[0].tag, ".vs"}, 32'(vga_vs), 32'(sb[0].vs));
                end
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
        if (resetn) begin
            c++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = c;
            end
        end else begin
            c = 0;
        end
        score();
    endtask

    task automatic run_to(input int n);
        while (c < n) clk1();
    endtask

    task automatic chk_rst(input string p);
        chk({p, ".vga_clk"}, 32'(vga_clk), 32'd0);
        chk({p, ".fb_addr"}, 32'(fb_addr), 32'd0);
        chk({p, ".hs"}, 32'(vga_hs), 32'd1);
        chk({p, ".vs"}, 32'(vga_vs), 32'd1);
        chk({p, ".blank_n"}, 32'(vga_blank_n), 32'd0);
        chk({p, ".rgb"}, {8'h00, vga_r, vga_g, vga_b}, 32'd0);
        chk({p, ".frame_start"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        int hs_first;
        int hs_lo;
        int vs_first;
        int vs_lo;

        resetn = 1'b0;
        repeat (5) clk1();
        chk_rst("rst");

        for (int h = 0; h < 8; h++) push(h, 0, $sformatf("l0_h%0d", h));
        push(645, 0, "l0_blank");
        resetn = 1'b1;
        clk1();
        chk("tick.c1", 32'(vga_clk), 32'd1);
        clk1();
        chk("tick.c2", 32'(vga_clk), 32'd0);

        hs_first = -1;
        hs_lo    = 0;
        while (c < 1600) begin
            clk1();
            if (vga_hs === 1'b0) begin
                hs_lo++;
                if (hs_first < 0) hs_first = c;
            end
        end
        chk("hs.fall_clk", 32'(hs_first), 32'd1316);
        chk("hs.low_clks", 32'(hs_lo), 32'd192);

        run_to(1700);
        ovr = 1'b1;
        push(100, 1, "ovr_vis");
        push(700, 1, "ovr_blank");
        run_to(3100);
        ovr = 1'b0;

        push(3, 3, "a_3_3");
        push(0, 4, "a_0_4");
        push(639, 4, "a_639_4");
        push(640, 4, "a_640_4");
        run_to(320600);
        chk("fs.none_yet", 32'(fs_cnt), 32'd0);
        chk("sb.drain1", 32'(sb.size()), 32'd0);

        resetn = 1'b0;
        clk1();
        chk_rst("mid");

        push(0, 0, "r_0_0");
        push(4, 0, "r_4_0");
        push(639, 479, "r_max");
        push(640, 479, "r_640_479");
        resetn   = 1'b1;
        fs_cnt   = 0;
        fs_first = -1;
        clk1();
        chk("mid.tick", 32'(vga_clk), 32'd1);

        vs_first = -1;
        vs_lo    = 0;
        while (c < 840100) begin
            clk1();
            if (vga_vs === 1'b0) begin
                vs_lo++;
                if (vs_first < 0) vs_first = c;
            end
        end
        chk("vs.fall_clk", 32'(vs_first), 32'd784004);
        chk("vs.low_clks", 32'(vs_lo), 32'd3200);
        chk("fs.first_clk", 32'(fs_first), 32'd840000);
        chk("fs.pulses", 32'(fs_cnt), 32'd1);
        chk("sb.drain2", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
